// File: rtl/cache_controller.sv
// Miss-handling FSM for the 2-way, 8-set, 32-byte-line write-back data cache.
// Sequences datapath strobes for hits, dirty evictions and line fills; keeps event counters.
module cache_controller (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  output logic        cpu_ready,
  output logic        busy,
  input  logic        hit,
  input  logic        lru_valid,
  input  logic        lru_dirty,
  input  logic [23:0] victim_tag,
  output logic        addr_valid,
  output logic        update_lru,
  output logic        set_dirty,
  output logic        update_cacheline,
  output logic        update_tag,
  output logic        set_valid,
  output logic        clear_dirty,
  output logic        clear_valid,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  output logic [31:0] mem_line_addr,
  input  logic        mem_ack,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
  output logic [31:0] wb_cnt
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

  state_t state;
  logic   refill;
  logic   req;
  logic   fill;

  assign req         = cpu_read | cpu_write;
  assign busy        = (state != IDLE);
  assign clear_valid = 1'b0;

  // Hit-path and fill strobes must act in the same cycle as the lookup / mem_ack,
  // so they are decoded from the registered state; RST masks them.
  assign fill = !RST && (state == FETCH) && mem_ack;

  always_comb begin
    addr_valid = 1'b0;
    update_lru = 1'b0;
    set_dirty  = 1'b0;
    cpu_ready  = 1'b0;
    if (!RST && (state == IDLE) && req && hit) begin
      addr_valid = 1'b1;
      update_lru = 1'b1;
      set_dirty  = cpu_write;
      cpu_ready  = 1'b1;
    end
  end

  assign update_cacheline = fill;
  assign update_tag       = fill;
  assign set_valid        = fill;
  assign clear_dirty      = fill;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= IDLE;
      refill        <= 1'b0;
      mem_rd_req    <= 1'b0;
      mem_wr_req    <= 1'b0;
      mem_line_addr <= '0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
      wb_cnt        <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          if (hit) begin
            // the re-lookup right after a fill is the tail of a miss, not a new hit
            if (!refill) hit_cnt <= hit_cnt + 32'd1;
            refill <= 1'b0;
          end else begin
            miss_cnt <= miss_cnt + 32'd1;
            if (lru_valid && lru_dirty) begin
              state         <= WRITEBACK;
              mem_wr_req    <= 1'b1;
              mem_line_addr <= {victim_tag, cpu_addr[7:5], 5'b0};
            end else begin
              state         <= FETCH;
              mem_rd_req    <= 1'b1;
              mem_line_addr <= {cpu_addr[31:5], 5'b0};
            end
          end
        end
        WRITEBACK: if (mem_ack) begin
          wb_cnt        <= wb_cnt + 32'd1;
          state         <= FETCH;
          mem_wr_req    <= 1'b0;
          mem_rd_req    <= 1'b1;
          mem_line_addr <= {cpu_addr[31:5], 5'b0};
        end
        FETCH: if (mem_ack) begin
          state         <= IDLE;
          mem_rd_req    <= 1'b0;
          mem_line_addr <= '0;
          refill        <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
